// File: rtl/lsu_pkg.sv
// Shared types and widths for the LSU load read path.
package lsu_pkg;

  localparam int AXI_DW  = 64;
  localparam int RAM_DW  = 128;
  localparam int RAM_AW  = 12;
  localparam int DRAM_AW = 31;
  localparam int ID_W    = 8;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_RD    = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } ld_st_e;

endpackage

// File: rtl/lsu_beat_packer.sv
// Pairs 64-bit R beats into RAM rows at consecutive (wrapping) addresses.
// Row writes are registered: strobes follow the odd beat or flush by one cycle.
module lsu_beat_packer
  import lsu_pkg::*;
#(
  parameter int AXI_DW = 64,
  parameter int RAM_AW = 12
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [RAM_AW-1:0]     i_row_addr,
  input  logic                  i_wram,
  input  logic                  i_beat_vld,
  input  logic [AXI_DW-1:0]     i_beat_dat,
  input  logic                  i_flush,
  output logic                  o_parity,
  output logic                  o_iram_wen,
  output logic                  o_wram_wen,
  output logic [RAM_AW-1:0]     o_waddr,
  output logic [2*AXI_DW-1:0]   o_wdata
);

  logic [AXI_DW-1:0]   r_low;
  logic                r_parity;
  logic [RAM_AW-1:0]   r_row;
  logic                r_wram;
  logic                r_iram_wen;
  logic                r_wram_wen;
  logic [RAM_AW-1:0]   r_waddr;
  logic [2*AXI_DW-1:0] r_wdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_low      <= '0;
      r_parity   <= 1'b0;
      r_row      <= '0;
      r_wram     <= 1'b0;
      r_iram_wen <= 1'b0;
      r_wram_wen <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_iram_wen <= 1'b0;
      r_wram_wen <= 1'b0;
      if (i_start) begin
        r_row    <= i_row_addr;
        r_wram   <= i_wram;
        r_parity <= 1'b0;
      end else if (i_beat_vld) begin
        if (!r_parity) begin
          r_low    <= i_beat_dat;
          r_parity <= 1'b1;
        end else begin
          r_iram_wen <= ~r_wram;
          r_wram_wen <= r_wram;
          r_waddr    <= r_row;
          r_wdata    <= {i_beat_dat, r_low};
          r_row      <= r_row + RAM_AW'(1);
          r_parity   <= 1'b0;
        end
      end else if (i_flush) begin
        // Unpaired final beat: upper half of the row is zero-filled.
        r_iram_wen <= ~r_wram;
        r_wram_wen <= r_wram;
        r_waddr    <= r_row;
        r_wdata    <= {{AXI_DW{1'b0}}, r_low};
        r_row      <= r_row + RAM_AW'(1);
        r_parity   <= 1'b0;
      end
    end
  end

  assign o_parity   = r_parity;
  assign o_iram_wen = r_iram_wen;
  assign o_wram_wen = r_wram_wen;
  assign o_waddr    = r_waddr;
  assign o_wdata    = r_wdata;

endmodule

// File: rtl/lsu_ld_axi_rd.sv
// Load engine: one AXI read burst -> 128-bit IRAM/WRAM rows, first write 4 cycles after accept, R always ready.
// Define LSU_LD_PERF_CNT_EN to add the ld_cycles accept-to-done cycle counter output.
module lsu_ld_axi_rd
  import lsu_pkg::*;
#(
  parameter int AXI_DW  = 64,
  parameter int RAM_DW  = 128,
  parameter int RAM_AW  = 12,
  parameter int DRAM_AW = 31,
  parameter int ID_W    = 8
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic [DRAM_AW-1:0] cmd_dram_addr,
  input  logic [7:0]         cmd_len,
  input  logic [RAM_AW-1:0]  cmd_ram_addr,
  input  logic               cmd_wram,
  input  logic [ID_W-1:0]    cmd_id,
  output logic               lsu_axi_arvld,
  output logic [DRAM_AW-1:0] lsu_axi_araddr,
  output logic [7:0]         lsu_axi_arlen,
  output logic [ID_W-1:0]    lsu_axi_arid,
  input  logic               axi_lsu_arrdy,
  input  logic               axi_lsu_rvld,
  input  logic [ID_W-1:0]    axi_lsu_rid,
  input  logic [AXI_DW-1:0]  axi_lsu_rdata,
  input  logic [1:0]         axi_lsu_rresp,
  input  logic               axi_lsu_rlast,
  output logic               lsu_axi_rrdy,
  output logic               iram_wen,
  output logic               wram_wen,
  output logic [RAM_AW-1:0]  ram_waddr,
  output logic [RAM_DW-1:0]  ram_wdata,
  output logic               ld_done,
  output logic               ld_err
`ifdef LSU_LD_PERF_CNT_EN
  ,
  output logic [15:0]        ld_cycles
`endif
);

  ld_st_e             r_state;
  ld_st_e             w_nxt;
  logic [DRAM_AW-1:0] r_araddr;
  logic [7:0]         r_arlen;
  logic [ID_W-1:0]    r_arid;
  logic               r_err;
  logic [8:0]         r_beat_cnt;

  logic w_acc;
  logic w_r_hs;
  logic w_flush;
  logic w_parity;
  logic w_beat_bad;
  logic w_cnt_bad;

  assign w_acc   = (r_state == ST_IDLE) && cmd_vld;
  assign w_r_hs  = (r_state == ST_RD) && axi_lsu_rvld;
  assign w_flush = (r_state == ST_FLUSH);

  assign w_beat_bad = (axi_lsu_rresp != AXI_RESP_OKAY) || (axi_lsu_rid != r_arid);
  // r_beat_cnt is the index of the current beat; rlast must land exactly on index len.
  assign w_cnt_bad  = axi_lsu_rlast ? (r_beat_cnt != {1'b0, r_arlen})
                                    : (r_beat_cnt >= {1'b0, r_arlen});

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_vld) w_nxt = ST_AR;
      ST_AR:    if (axi_lsu_arrdy) w_nxt = ST_RD;
      ST_RD:    if (axi_lsu_rvld && axi_lsu_rlast) w_nxt = w_parity ? ST_DONE : ST_FLUSH;
      ST_FLUSH: w_nxt = ST_DONE;
      ST_DONE:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= ST_IDLE;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arid     <= '0;
      r_err      <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_araddr   <= cmd_dram_addr;
        r_arlen    <= cmd_len;
        r_arid     <= cmd_id;
        r_err      <= 1'b0;
        r_beat_cnt <= '0;
      end else if (w_r_hs) begin
        if (w_beat_bad || w_cnt_bad) r_err <= 1'b1;
        if (r_beat_cnt != 9'h1FF) r_beat_cnt <= r_beat_cnt + 9'd1;
      end
    end
  end

  lsu_beat_packer #(
    .AXI_DW (AXI_DW),
    .RAM_AW (RAM_AW)
  ) u_packer (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_start    (w_acc),
    .i_row_addr (cmd_ram_addr),
    .i_wram     (cmd_wram),
    .i_beat_vld (w_r_hs),
    .i_beat_dat (axi_lsu_rdata),
    .i_flush    (w_flush),
    .o_parity   (w_parity),
    .o_iram_wen (iram_wen),
    .o_wram_wen (wram_wen),
    .o_waddr    (ram_waddr),
    .o_wdata    (ram_wdata)
  );

  // cmd_rdy is forced low while reset is held so every output reads 0 in reset.
  assign cmd_rdy        = (r_state == ST_IDLE) && !rst_n;
  assign lsu_axi_arvld  = (r_state == ST_AR);
  assign lsu_axi_araddr = r_araddr;
  assign lsu_axi_arlen  = r_arlen;
  assign lsu_axi_arid   = r_arid;
  assign lsu_axi_rrdy   = (r_state == ST_RD);
  assign ld_done        = (r_state == ST_DONE);
  assign ld_err         = (r_state == ST_DONE) && r_err;

`ifdef LSU_LD_PERF_CNT_EN
  logic [15:0] r_cyc_cnt;
  logic [15:0] r_ld_cycles;
  logic [16:0] w_cyc_inc;
  logic [16:0] w_cyc_fin;

  assign w_cyc_inc = {1'b0, r_cyc_cnt} + 17'd1;
  // r_cyc_cnt excludes the current cycle; +2 adds it and the DONE cycle that follows.
  assign w_cyc_fin = {1'b0, r_cyc_cnt} + 17'd2;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cyc_cnt   <= '0;
      r_ld_cycles <= '0;
    end else begin
      if (w_acc) begin
        r_cyc_cnt <= 16'd1;
      end else if (r_state != ST_IDLE) begin
        r_cyc_cnt <= w_cyc_inc[16] ? 16'hFFFF : w_cyc_inc[15:0];
      end
      if ((w_nxt == ST_DONE) && (r_state != ST_DONE)) begin
        r_ld_cycles <= w_cyc_fin[16] ? 16'hFFFF : w_cyc_fin[15:0];
      end
    end
  end

  assign ld_cycles = r_ld_cycles;
`endif

endmodule
